// File: rtl/caf_pkg.sv
// Shared definitions for the CAF datapath: sequencer state encoding and default widths.
package caf_pkg;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } ctrl_state_t;

    localparam int DEF_SAMPLE_BITS = 12;
    localparam int DEF_SUM_BITS    = 32;
    localparam int DEF_INDEX_BITS  = 16;

endpackage

// File: rtl/sample_window_packer.sv
// Sliding window of LENGTH samples for one complex component; newest sample in slot 0
// (LSBs), oldest in the top slot. Synchronous clear and shift enable.
module sample_window_packer #(
    parameter int BITS   = 12,
    parameter int LENGTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_shift,
    input  logic                     i_clear,
    input  logic [BITS-1:0]          i_sample,
    output logic [BITS*LENGTH-1:0]   o_vec
);

    genvar gi;
    generate
        for (gi = 0; gi < LENGTH; gi++) begin : g_slot
            logic [BITS-1:0] r_slot;
            if (gi == 0) begin : g_head
                always_ff @(posedge clk) begin
                    if (reset || i_clear) begin
                        r_slot <= '0;
                    end else if (i_shift) begin
                        r_slot <= i_sample;
                    end
                end
            end else begin : g_tail
                always_ff @(posedge clk) begin
                    if (reset || i_clear) begin
                        r_slot <= '0;
                    end else if (i_shift) begin
                        r_slot <= g_slot[gi-1].r_slot;
                    end
                end
            end
            assign o_vec[gi*BITS +: BITS] = r_slot;
        end
    endgenerate

endmodule

// File: rtl/dot_prod_ctrl.sv
// Per-lag sequencer: packs sample pairs into sliding windows, requests one dot product
// per window and forwards the tagged result. Optional WAIT timeout: DOT_PROD_CTRL_TIMEOUT_EN.
module dot_prod_ctrl
    import caf_pkg::*;
#(
    parameter int LENGTH         = 8,
    parameter int STRIDE         = 1,
    parameter int XI_BITS        = DEF_SAMPLE_BITS,
    parameter int XQ_BITS        = DEF_SAMPLE_BITS,
    parameter int YI_BITS        = DEF_SAMPLE_BITS,
    parameter int YQ_BITS        = DEF_SAMPLE_BITS,
    parameter int SUM_I_SIZE     = DEF_SUM_BITS,
    parameter int SUM_Q_SIZE     = DEF_SUM_BITS,
    parameter int INDEX_BITS     = DEF_INDEX_BITS,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          s_axis_sample_tvalid,
    output logic                          s_axis_sample_tready,
    input  logic [XI_BITS-1:0]            xi_in,
    input  logic [XQ_BITS-1:0]            xq_in,
    input  logic [YI_BITS-1:0]            yi_in,
    input  logic [YQ_BITS-1:0]            yq_in,
    output logic                          m_axis_x_tvalid,
    output logic                          m_axis_y_tvalid,
    output logic [XI_BITS*LENGTH-1:0]     xi,
    output logic [XQ_BITS*LENGTH-1:0]     xq,
    output logic [YI_BITS*LENGTH-1:0]     yi,
    output logic [YQ_BITS*LENGTH-1:0]     yq,
    output logic                          m_axis_product_tready,
    input  logic                          s_axis_product_tvalid,
    input  logic [SUM_I_SIZE-1:0]         i,
    input  logic [SUM_Q_SIZE-1:0]         q,
    output logic                          m_axis_result_tvalid,
    input  logic                          m_axis_result_tready,
    output logic [SUM_I_SIZE-1:0]         result_i,
    output logic [SUM_Q_SIZE-1:0]         result_q,
    output logic [INDEX_BITS-1:0]         result_index,
    output logic                          timeout_err
);

    localparam int NEED_W = $clog2(LENGTH + 1);
    localparam logic [NEED_W-1:0] NEED_FULL   = NEED_W'(LENGTH);
    localparam logic [NEED_W-1:0] NEED_STRIDE = NEED_W'(STRIDE);

    ctrl_state_t              r_state;
    ctrl_state_t              w_state_next;
    logic [NEED_W-1:0]        r_need;
    logic                     r_armed;
    logic [SUM_I_SIZE-1:0]    r_result_i;
    logic [SUM_Q_SIZE-1:0]    r_result_q;
    logic [INDEX_BITS-1:0]    r_index;

    logic w_sample_tready;
    logic w_req_valid;
    logic w_prod_tready;
    logic w_res_valid;
    logic w_accept;
    logic w_capture;
    logic w_release;
    logic w_timeout;

    // r_armed keeps every ready low for the first cycle after reset
    always_comb begin
        w_state_next    = r_state;
        w_sample_tready = 1'b0;
        w_req_valid     = 1'b0;
        w_prod_tready   = 1'b0;
        w_res_valid     = 1'b0;
        w_accept        = 1'b0;
        w_capture       = 1'b0;
        w_release       = 1'b0;
        case (r_state)
            ST_FILL: begin
                w_sample_tready = r_armed;
                w_accept        = r_armed && s_axis_sample_tvalid;
                if (w_accept && (r_need == NEED_W'(1))) begin
                    w_state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_req_valid  = 1'b1;
                w_state_next = ST_WAIT;
            end
            ST_WAIT: begin
                w_prod_tready = 1'b1;
                w_capture     = s_axis_product_tvalid;
                if (s_axis_product_tvalid) begin
                    w_state_next = ST_HOLD;
                end else if (w_timeout) begin
                    w_state_next = ST_FILL;
                end
            end
            ST_HOLD: begin
                w_res_valid = 1'b1;
                w_release   = m_axis_result_tready;
                if (m_axis_result_tready) begin
                    w_state_next = ST_FILL;
                end
            end
            default: w_state_next = ST_FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_FILL;
            r_need     <= NEED_FULL;
            r_armed    <= 1'b0;
            r_result_i <= '0;
            r_result_q <= '0;
            r_index    <= '0;
        end else begin
            r_state <= w_state_next;
            r_armed <= 1'b1;
            if (w_accept) begin
                r_need <= r_need - NEED_W'(1);
            end
            if (w_capture) begin
                r_result_i <= i;
                r_result_q <= q;
            end
            // a dropped window still consumes its index
            if (w_release || w_timeout) begin
                r_index <= r_index + INDEX_BITS'(1);
                r_need  <= NEED_STRIDE;
            end
        end
    end

`ifdef DOT_PROD_CTRL_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WAIT_W-1:0] r_wait_cnt;
    logic              r_timeout_err;

    assign w_timeout = (r_state == ST_WAIT) && !s_axis_product_tvalid
                       && (r_wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wait_cnt    <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_timeout_err <= w_timeout;
            if (r_state != ST_WAIT) begin
                r_wait_cnt <= '0;
            end else begin
                r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
            end
        end
    end

    assign timeout_err = r_timeout_err;
`else
    logic w_unused_timeout_cfg;
    assign w_unused_timeout_cfg = |32'(TIMEOUT_CYCLES);
    assign w_timeout            = 1'b0;
    assign timeout_err          = 1'b0;
`endif

    sample_window_packer #(.BITS(XI_BITS), .LENGTH(LENGTH)) u_pack_xi (
        .clk(clk), .reset(reset), .i_shift(w_accept), .i_clear(1'b0),
        .i_sample(xi_in), .o_vec(xi)
    );
    sample_window_packer #(.BITS(XQ_BITS), .LENGTH(LENGTH)) u_pack_xq (
        .clk(clk), .reset(reset), .i_shift(w_accept), .i_clear(1'b0),
        .i_sample(xq_in), .o_vec(xq)
    );
    sample_window_packer #(.BITS(YI_BITS), .LENGTH(LENGTH)) u_pack_yi (
        .clk(clk), .reset(reset), .i_shift(w_accept), .i_clear(1'b0),
        .i_sample(yi_in), .o_vec(yi)
    );
    sample_window_packer #(.BITS(YQ_BITS), .LENGTH(LENGTH)) u_pack_yq (
        .clk(clk), .reset(reset), .i_shift(w_accept), .i_clear(1'b0),
        .i_sample(yq_in), .o_vec(yq)
    );

    assign s_axis_sample_tready  = w_sample_tready;
    assign m_axis_x_tvalid       = w_req_valid;
    assign m_axis_y_tvalid       = w_req_valid;
    assign m_axis_product_tready = w_prod_tready;
    assign m_axis_result_tvalid  = w_res_valid;
    assign result_i              = r_result_i;
    assign result_q              = r_result_q;
    assign result_index          = r_index;

endmodule

// File: tb/tb_dot_prod_ctrl.sv
// Self-checking bench for dot_prod_ctrl (LENGTH=4, STRIDE=2) against a sample-history model.
module tb_dot_prod_ctrl;
    localparam int L  = 4;
    localparam int S  = 2;
    localparam int B  = 12;
    localparam int W  = 32;
    localparam int IB = 16;
    localparam int TO = 20;

    logic clk = 1'b0;
    logic reset;
    logic s_tvalid, s_tready;
    logic [B-1:0] xi_in, xq_in, yi_in, yq_in;
    logic x_tvalid, y_tvalid;
    logic [B*L-1:0] xi, xq, yi, yq;
    logic p_tready, p_tvalid;
    logic [W-1:0] p_i, p_q;
    logic r_tvalid, r_tready;
    logic [W-1:0] result_i, result_q;
    logic [IB-1:0] result_index;
    logic timeout_err;

    int n_vec = 0;
    int n_err = 0;

    // reference model: every accepted sample pair {xi,xq,yi,yq}, oldest first
    logic [4*B-1:0] hist[$];
    int need_m;
    int exp_index;
    logic [W-1:0] exp_ri, exp_rq;

    always #5 clk = ~clk;

    dot_prod_ctrl #(
        .LENGTH(L), .STRIDE(S), .XI_BITS(B), .XQ_BITS(B), .YI_BITS(B), .YQ_BITS(B),
        .SUM_I_SIZE(W), .SUM_Q_SIZE(W), .INDEX_BITS(IB), .TIMEOUT_CYCLES(TO)
    ) u_dut (
        .clk(clk), .reset(reset),
        .s_axis_sample_tvalid(s_tvalid), .s_axis_sample_tready(s_tready),
        .xi_in(xi_in), .xq_in(xq_in), .yi_in(yi_in), .yq_in(yq_in),
        .m_axis_x_tvalid(x_tvalid), .m_axis_y_tvalid(y_tvalid),
        .xi(xi), .xq(xq), .yi(yi), .yq(yq),
        .m_axis_product_tready(p_tready), .s_axis_product_tvalid(p_tvalid),
        .i(p_i), .q(p_q),
        .m_axis_result_tvalid(r_tvalid), .m_axis_result_tready(r_tready),
        .result_i(result_i), .result_q(result_q), .result_index(result_index),
        .timeout_err(timeout_err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, expv);
            $error("miscompare in %s", tag);
        end
    endtask

    // window of component c (0=xi,1=xq,2=yi,3=yq): last L samples, oldest in the top slot
    function automatic logic [B*L-1:0] exp_vec(input int c);
        logic [B*L-1:0] v;
        logic [4*B-1:0] p;
        int n;
        int idx;
        v = '0;
        n = hist.size();
        for (int k = 0; k < L; k++) begin
            idx = n - L + k;
            p = (idx >= 0) ? hist[idx] : '0;
            v = (v << B) | (B*L)'(p[(3-c)*B +: B]);
        end
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [B-1:0] a, input logic [B-1:0] b, input logic [B-1:0] c,
                        input logic [B-1:0] d, input int idle, input bit last);
        int cnt;
        repeat (idle) tick();
        xi_in = a; xq_in = b; yi_in = c; yq_in = d;
        s_tvalid = 1'b1;
        cnt = 0;
        while (s_tready !== 1'b1 && cnt < 100) begin
            tick();
            cnt++;
        end
        check("sample_tready_wait", 64'(s_tready), 64'd1);
        tick();
        s_tvalid = 1'b0;
        hist.push_back({a, b, c, d});
        if (!last) check("no_early_request", 64'(x_tvalid), 64'd0);
    endtask

    task automatic fill_random();
        for (int k = 0; k < need_m; k++)
            beat(B'($urandom), B'($urandom), B'($urandom), B'($urandom),
                 int'($urandom_range(0, 2)), k == need_m - 1);
    endtask

    task automatic check_request();
        check("x_tvalid", 64'(x_tvalid), 64'd1);
        check("y_tvalid", 64'(y_tvalid), 64'd1);
        check("xi_vec", 64'(xi), 64'(exp_vec(0)));
        check("xq_vec", 64'(xq), 64'(exp_vec(1)));
        check("yi_vec", 64'(yi), 64'(exp_vec(2)));
        check("yq_vec", 64'(yq), 64'(exp_vec(3)));
        check("issue_sample_tready", 64'(s_tready), 64'd0);
        check("issue_prod_tready", 64'(p_tready), 64'd0);
        tick();
        check("req_one_cycle", 64'(x_tvalid), 64'd0);
        check("wait_prod_tready", 64'(p_tready), 64'd1);
    endtask

    task automatic give_product(input logic [W-1:0] vi, input logic [W-1:0] vq, input int delay);
        repeat (delay) begin
            tick();
            check("wait_prod_tready_hold", 64'(p_tready), 64'd1);
            check("wait_no_result", 64'(r_tvalid), 64'd0);
        end
        p_i = vi; p_q = vq; p_tvalid = 1'b1;
        tick();
        p_tvalid = 1'b0;
        exp_ri = vi; exp_rq = vq;
        check("result_tvalid", 64'(r_tvalid), 64'd1);
        check("result_i", 64'(result_i), 64'(exp_ri));
        check("result_q", 64'(result_q), 64'(exp_rq));
        check("result_index", 64'(result_index), 64'(IB'(exp_index)));
    endtask

    task automatic release_result(input int stall);
        r_tready = 1'b0;
        repeat (stall) begin
            tick();
            check("hold_tvalid", 64'(r_tvalid), 64'd1);
            check("hold_result_i", 64'(result_i), 64'(exp_ri));
            check("hold_sample_tready", 64'(s_tready), 64'd0);
            check("hold_no_request", 64'(x_tvalid), 64'd0);
        end
        r_tready = 1'b1;
        tick();
        r_tready = 1'b0;
        exp_index++;
        need_m = S;
        check("released_tvalid", 64'(r_tvalid), 64'd0);
        check("released_sample_tready", 64'(s_tready), 64'd1);
        check("no_timeout_err", 64'(timeout_err), 64'd0);
    endtask

    initial begin
        reset = 1'b1; s_tvalid = 1'b0; p_tvalid = 1'b0; r_tready = 1'b0;
        xi_in = '0; xq_in = '0; yi_in = '0; yq_in = '0; p_i = '0; p_q = '0;
        need_m = L; exp_index = 0; exp_ri = '0; exp_rq = '0;
        repeat (3) tick();
        check("rst_sample_tready", 64'(s_tready), 64'd0);
        check("rst_x_tvalid", 64'(x_tvalid), 64'd0);
        check("rst_prod_tready", 64'(p_tready), 64'd0);
        check("rst_result_tvalid", 64'(r_tvalid), 64'd0);
        check("rst_xi", 64'(xi), 64'd0);
        check("rst_result_i", 64'(result_i), 64'd0);
        check("rst_index", 64'(result_index), 64'd0);
        check("rst_timeout", 64'(timeout_err), 64'd0);
        reset = 1'b0;
        tick();
        check("post_rst_tready", 64'(s_tready), 64'd1);

        // window 0: directed 1..4, product (30,-5), 10-cycle downstream stall
        for (int k = 1; k <= 4; k++)
            beat(B'(k), B'($urandom), B'($urandom), B'($urandom), 0, k == 4);
        check("fill_xi_const", 64'(xi), 64'h001002003004);
        check_request();
        give_product(32'd30, -32'sd5, 2);
        check("result_q_neg5", 64'(result_q), 64'hFFFFFFFB);
        release_result(10);

        // window 1: stride-2 slide with 5,6
        beat(B'(5), B'($urandom), B'($urandom), B'($urandom), 0, 1'b0);
        beat(B'(6), B'($urandom), B'($urandom), B'($urandom), 0, 1'b1);
        check("stride2_xi_const", 64'(xi), 64'h003004005006);
        check_request();
        give_product(W'($urandom), W'($urandom), 0);
        release_result(0);

        // stray product while filling is ignored
        p_tvalid = 1'b1; p_i = W'($urandom); p_q = W'($urandom);
        tick();
        tick();
        p_tvalid = 1'b0;
        check("stray_prod_result_i", 64'(result_i), 64'(exp_ri));
        check("stray_prod_tvalid", 64'(r_tvalid), 64'd0);

        // window 2: negative sample next to a small positive one
        beat(12'hFFF, 12'h800, B'($urandom), B'($urandom), 0, 1'b0);
        beat(B'(7), B'(1), B'($urandom), B'($urandom), 0, 1'b1);
        check("neg_xi_const", 64'(xi), 64'h005006FFF007);
        check_request();
        give_product(W'($urandom), W'($urandom), 1);
        release_result(1);

        for (int w = 0; w < 8; w++) begin
            fill_random();
            check_request();
            give_product(W'($urandom), W'($urandom), int'($urandom_range(0, 4)));
            release_result(int'($urandom_range(0, 3)));
        end

        // reset while waiting for a product; the late product must be dropped
        fill_random();
        check_request();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rstw_sample_tready", 64'(s_tready), 64'd0);
        check("rstw_prod_tready", 64'(p_tready), 64'd0);
        check("rstw_result_tvalid", 64'(r_tvalid), 64'd0);
        check("rstw_xi", 64'(xi), 64'd0);
        check("rstw_index", 64'(result_index), 64'd0);
        hist.delete();
        need_m = L; exp_index = 0; exp_ri = '0; exp_rq = '0;
        p_tvalid = 1'b1; p_i = W'($urandom); p_q = W'($urandom);
        tick();
        p_tvalid = 1'b0;
        check("late_prod_tvalid", 64'(r_tvalid), 64'd0);
        check("late_prod_result_i", 64'(result_i), 64'd0);
        fill_random();
        check_request();
        give_product(W'($urandom), W'($urandom), 0);
        release_result(0);

`ifdef DOT_PROD_CTRL_TIMEOUT_EN
        fill_random();
        check_request();
        repeat (TO - 1) begin
            tick();
            check("to_quiet", 64'(timeout_err), 64'd0);
        end
        tick();
        check("to_pulse", 64'(timeout_err), 64'd1);
        check("to_back_to_fill", 64'(s_tready), 64'd1);
        exp_index++;
        need_m = S;
        tick();
        check("to_pulse_end", 64'(timeout_err), 64'd0);
        fill_random();
        check_request();
        give_product(W'($urandom), W'($urandom), 0);
        release_result(0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench did not finish");
    end

endmodule
